// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver/transmitter types and parity helper
package uart_pkg;

   localparam int MAX_DATA_BITS = 16;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} rx_state_t;

   // Parity bit a transmitter appends; a receiver XORs in the received bit to get the error.
   function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with mid-bit and end-of-bit ticks
module uart_baud_gen #(
   parameter int BAUD_DIV = 109
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic half_tick,
   output logic full_tick
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || cnt == FULL) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign half_tick = (cnt == HALF);
   assign full_tick = (cnt == FULL);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with error flags and rdy/clr_rdy handshake
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int BAUD_DIV   = 109,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 RX,
   input  logic                 clr_rdy,
   output logic                 rdy,
   output logic [DATA_BITS-1:0] cmd,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int BCW = $clog2(DATA_BITS + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);
   localparam logic ODD     = (PARITY_ODD != 0);
   localparam logic HAS_PAR = (PARITY_EN != 0);

   rx_state_t state, next_state;

   logic                 rx_meta, rx_s;
   logic                 half_tick, full_tick, cnt_clr;
   logic [BCW-1:0]       bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 p_err, stop_sample;
   logic                 frame_start, shift_en, par_en, stop_en, done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
      end
   end

   uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (cnt_clr),
      .half_tick (half_tick),
      .full_tick (full_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!rx_s) next_state = START;
         START:   if (half_tick) next_state = rx_s ? IDLE : DATA;
         DATA:    if (full_tick && bit_cnt == LAST_BIT) next_state = HAS_PAR ? PARITY : STOP;
         PARITY:  if (full_tick) next_state = STOP;
         STOP:    if (full_tick) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Every state change restarts the bit period, so DATA ticks land mid-bit.
   always_comb begin
      busy        = (state != IDLE);
      cnt_clr     = (next_state != state);
      frame_start = (state == START) && (next_state == DATA);
      shift_en    = (state == DATA) && full_tick;
      par_en      = (state == PARITY) && full_tick;
      stop_en     = (state == STOP) && full_tick;
      done        = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt     <= '0;
         shreg       <= '0;
         p_err       <= 1'b0;
         stop_sample <= 1'b0;
         cmd         <= '0;
         rdy         <= 1'b0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (frame_start) begin
            bit_cnt <= '0;
            p_err   <= 1'b0;
         end
         if (shift_en) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BCW'(1);
         end
         if (par_en)  p_err <= parity_calc(MAX_DATA_BITS'(shreg), ODD) ^ rx_s;
         if (stop_en) stop_sample <= rx_s;
         // A word landing together with clr_rdy is fresh, so it is not an overrun.
         if (done) begin
            cmd        <= shreg;
            rdy        <= 1'b1;
            frame_err  <= ~stop_sample;
            parity_err <= p_err;
            overrun    <= ~clr_rdy & (overrun | rdy);
         end else if (clr_rdy) begin
            rdy        <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized self-checking bench for uart_rx_param (8N1 and 7E1 instances)
module tb_uart_rx_param;

   localparam int B = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] rx, clr;
   logic [1:0] rdy, fe, pe, ov, busy;
   logic [7:0] cmd0;
   logic [6:0] cmd1;
   logic [8:0] dcmd [2];

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   // Frame registrations written by the stimulus, consumed by the model process.
   int         reg_seq [2] = '{0, 0};
   int         reg_due [2], reg_blo [2], reg_bhi [2];
   logic [8:0] reg_cmd [2];
   logic       reg_fe [2], reg_pe [2], reg_deliver [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_param #(.DATA_BITS(8), .BAUD_DIV(B), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .RX(rx[0]), .clr_rdy(clr[0]), .rdy(rdy[0]), .cmd(cmd0),
      .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]), .busy(busy[0]));

   uart_rx_param #(.DATA_BITS(7), .BAUD_DIV(B), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .RX(rx[1]), .clr_rdy(clr[1]), .rdy(rdy[1]), .cmd(cmd1),
      .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]), .busy(busy[1]));

   assign dcmd[0] = {1'b0, cmd0};
   assign dcmd[1] = {2'b00, cmd1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // rdy rises this many edges after RX is driven low: two synchroniser stages,
   // one cycle to see the start, half a bit to mid-start, one period per
   // remaining bit, and the DONE cycle.
   function automatic int latency(input int i);
      return 4 + B / 2 + ((i == 1 ? 7 : 8) + i + 1) * B;
   endfunction

   task automatic send_frame(input int i, input logic [8:0] data, input logic pbit, input logic stop);
      int         n;
      logic [8:0] dm;
      n  = (i == 1) ? 7 : 8;
      dm = data & 9'((1 << n) - 1);
      reg_due[i]     = cyc + latency(i);
      reg_blo[i]     = cyc + 3;
      reg_bhi[i]     = cyc + latency(i);
      reg_cmd[i]     = dm;
      reg_fe[i]      = ~stop;
      reg_pe[i]      = (i == 1) && ((($countones(dm) + int'(pbit)) % 2) != 0);
      reg_deliver[i] = 1'b1;
      reg_seq[i]     = reg_seq[i] + 1;
      rx[i] = 1'b0;
      wait_edges(B);
      for (int k = 0; k < n; k++) begin
         rx[i] = data[k];
         wait_edges(B);
      end
      if (i == 1) begin
         rx[i] = pbit;
         wait_edges(B);
      end
      // A low stop bit is released just after its mid-point so it is not taken as a new start.
      rx[i] = stop;
      if (stop) begin
         wait_edges(B);
      end else begin
         wait_edges(B / 2 + 1);
         rx[i] = 1'b1;
         wait_edges(B - B / 2 - 1);
      end
      rx[i] = 1'b1;
   endtask

   task automatic pulse_clr(input int i);
      clr[i] = 1'b1;
      wait_edges(1);
      clr[i] = 1'b0;
   endtask

   // Behavioural model and per-cycle compare.
   initial begin
      logic       m_rdy [2], m_fe [2], m_pe [2], m_ov [2], clr_q [2], p_valid [2];
      logic       p_fe [2], p_pe [2], exp_busy;
      logic [8:0] m_cmd [2], p_cmd [2];
      int         seen [2], p_due [2], blo [2], bhi [2];
      for (int i = 0; i < 2; i++) begin
         m_rdy[i] = 0; m_fe[i] = 0; m_pe[i] = 0; m_ov[i] = 0; m_cmd[i] = 0;
         clr_q[i] = 0; p_valid[i] = 0; seen[i] = 0; blo[i] = 0; bhi[i] = 0;
         p_due[i] = 0; p_fe[i] = 0; p_pe[i] = 0; p_cmd[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
               m_rdy[i] = 0; m_fe[i] = 0; m_pe[i] = 0; m_ov[i] = 0; m_cmd[i] = 0;
               p_valid[i] = 0; seen[i] = reg_seq[i]; blo[i] = 0; bhi[i] = 0;
            end else begin
               if (reg_seq[i] != seen[i]) begin
                  seen[i]    = reg_seq[i];
                  p_valid[i] = reg_deliver[i];
                  p_due[i]   = reg_due[i];
                  p_cmd[i]   = reg_cmd[i];
                  p_fe[i]    = reg_fe[i];
                  p_pe[i]    = reg_pe[i];
                  blo[i]     = reg_blo[i];
                  bhi[i]     = reg_bhi[i];
               end
               if (p_valid[i] && p_due[i] == cyc) begin
                  m_ov[i]    = clr_q[i] ? 1'b0 : (m_ov[i] | m_rdy[i]);
                  m_rdy[i]   = 1'b1;
                  m_cmd[i]   = p_cmd[i];
                  m_fe[i]    = p_fe[i];
                  m_pe[i]    = p_pe[i];
                  p_valid[i] = 1'b0;
               end else if (clr_q[i]) begin
                  m_rdy[i] = 0; m_fe[i] = 0; m_pe[i] = 0; m_ov[i] = 0;
               end
            end
            clr_q[i] = clr[i];
            exp_busy = rst_n && (cyc >= blo[i]) && (cyc < bhi[i]);
            chk($sformatf("rdy%0d", i),   32'(rdy[i]),  32'(m_rdy[i]));
            chk($sformatf("cmd%0d", i),   32'(dcmd[i]), 32'(m_cmd[i]));
            chk($sformatf("fe%0d", i),    32'(fe[i]),   32'(m_fe[i]));
            chk($sformatf("pe%0d", i),    32'(pe[i]),   32'(m_pe[i]));
            chk($sformatf("ov%0d", i),    32'(ov[i]),   32'(m_ov[i]));
            chk($sformatf("busy%0d", i),  32'(busy[i]), 32'(exp_busy));
         end
      end
   end

   // Stimulus with hand-computed pins.
   initial begin
      int         c0;
      logic [8:0] d;
      rst_n = 1'b0;
      rx    = 2'b11;
      clr   = 2'b00;
      wait_edges(3);
      chk("reset_cmd0", 32'(cmd0), 32'h0);
      chk("reset_rdy", 32'(rdy), 32'h0);
      rst_n = 1'b1;
      wait_edges(3);

      c0 = cyc;
      fork
         send_frame(0, 9'hA5, 1'b0, 1'b1);
         begin
            wait_until(c0 + 155);
            chk("a5_rdy_before", 32'(rdy[0]), 32'h0);
            wait_until(c0 + 156);
            chk("a5_rdy_rise", 32'(rdy[0]), 32'h1);
            chk("a5_cmd", 32'(cmd0), 32'hA5);
            chk("a5_busy_low", 32'(busy[0]), 32'h0);
         end
      join
      wait_edges(1);

      send_frame(0, 9'h3C, 1'b0, 1'b0);
      chk("3c_cmd", 32'(cmd0), 32'h3C);
      chk("3c_fe", 32'(fe[0]), 32'h1);
      pulse_clr(0);
      chk("3c_clr_rdy", 32'(rdy[0]), 32'h0);
      chk("3c_clr_fe", 32'(fe[0]), 32'h0);
      chk("3c_cmd_kept", 32'(cmd0), 32'h3C);

      c0 = cyc;
      reg_blo[0] = c0 + 3;
      reg_bhi[0] = c0 + 3 + B / 2;
      reg_deliver[0] = 1'b0;
      reg_seq[0] = reg_seq[0] + 1;
      rx[0] = 1'b0;
      wait_edges(3);
      rx[0] = 1'b1;
      wait_until(c0 + 6);
      chk("glitch_busy_high", 32'(busy[0]), 32'h1);
      wait_until(c0 + 12);
      chk("glitch_busy_low", 32'(busy[0]), 32'h0);
      chk("glitch_no_rdy", 32'(rdy[0]), 32'h0);
      wait_edges(B);

      send_frame(0, 9'h11, 1'b0, 1'b1);
      send_frame(0, 9'h22, 1'b0, 1'b1);
      chk("b2b_cmd", 32'(cmd0), 32'h22);
      chk("b2b_ov", 32'(ov[0]), 32'h1);
      fork
         send_frame(0, 9'h33, 1'b0, 1'b1);
         begin
            wait_edges(155);
            clr[0] = 1'b1;
            wait_edges(1);
            clr[0] = 1'b0;
            chk("done_wins_rdy", 32'(rdy[0]), 32'h1);
            chk("done_wins_ov", 32'(ov[0]), 32'h0);
            chk("done_wins_cmd", 32'(cmd0), 32'h33);
         end
      join

      fork
         send_frame(0, 9'hFF, 1'b0, 1'b1);
         begin
            wait_edges(60);
            rst_n = 1'b0;
            wait_edges(3);
            rst_n = 1'b1;
         end
      join
      wait_edges(2);
      chk("abort_no_rdy", 32'(rdy[0]), 32'h0);
      send_frame(0, 9'h81, 1'b0, 1'b1);
      chk("after_reset_cmd", 32'(cmd0), 32'h81);
      chk("after_reset_flags", 32'({fe[0], pe[0], ov[0]}), 32'h0);

      send_frame(1, 9'h55, 1'b0, 1'b1);
      chk("p55_cmd", 32'(cmd1), 32'h55);
      chk("p55_pe0", 32'(pe[1]), 32'h0);
      send_frame(1, 9'h55, 1'b1, 1'b1);
      chk("p55_pe1", 32'(pe[1]), 32'h1);
      chk("p55_rdy", 32'(rdy[1]), 32'h1);

      for (int f = 0; f < 12; f++) begin
         for (int i = 0; i < 2; i++) begin
            d = 9'($urandom);
            send_frame(i, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0));
            if ($urandom_range(0, 1) == 1) pulse_clr(i);
            wait_edges($urandom_range(0, 20));
         end
      end

      wait_edges(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
